// File: rtl/crossing_pkg.sv
// Shared types and constants for the toggle-handshake crossing receiver.
package crossing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam int CNT_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/crossing_toggle_rx_if.sv
// Crossing bus between source register, receiver and consumer.
interface crossing_toggle_rx_if
  import crossing_pkg::*;
#(
  parameter int width = 1
);

  logic [width-1:0] D_CROSS;
  logic             REQ_TOG;
  logic             ACK_TOG;
  logic [width-1:0] D_OUT;
  logic             VALID;
  logic             DEQ;
  logic             PROTO_ERR;

  modport master (
    output D_CROSS,
    output REQ_TOG,
    output DEQ,
    input  ACK_TOG,
    input  D_OUT,
    input  VALID,
    input  PROTO_ERR
  );

  modport slave (
    input  D_CROSS,
    input  REQ_TOG,
    input  DEQ,
    output ACK_TOG,
    output D_OUT,
    output VALID,
    output PROTO_ERR
  );

endinterface

// File: rtl/crossing_sync_bit.sv
// Multi-flop single-bit synchroniser, cleared to 0 on reset.
module crossing_sync_bit
  import crossing_pkg::*;
#(
  parameter int stages = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [stages-1:0] ff;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ff <= '0;
    end else begin
      ff <= {ff[stages-2:0], D};
    end
  end

  assign Q = ff[stages-1];

endmodule

// File: rtl/crossing_toggle_rx.sv
// Destination-side receiver: sync request toggle, settle, capture, ack.
module crossing_toggle_rx
  import crossing_pkg::*;
#(
  parameter int               width       = 1,
  parameter logic [width-1:0] init        = '0,
  parameter int               sync_stages = 2,
  parameter int               settle      = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  crossing_toggle_rx_if.slave   bus
);

  localparam bit NO_SETTLE = (settle == 0);
  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'((settle > 0) ? settle - 1 : 0);

  logic             sync_out;
  logic             req_seen;
  logic             ack;
  logic             valid;
  logic             perr;
  logic             lvl;
  logic [width-1:0] dout;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  logic pending;
  logic space;
  logic capture;

  crossing_sync_bit #(
    .stages(sync_stages)
  ) u_req_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (bus.REQ_TOG),
    .Q  (sync_out)
  );

  assign pending = (sync_out != req_seen);
  assign space   = !valid || bus.DEQ;

  always_comb begin
    capture = 1'b0;
    unique case (state)
      IDLE:    capture = pending && NO_SETTLE && space;
      SETTLE:  capture = (cnt == '0) && space;
      HOLD:    capture = space;
      default: capture = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout     <= init;
      valid    <= 1'b0;
      req_seen <= 1'b0;
      ack      <= 1'b0;
    end else if (capture) begin
      dout     <= bus.D_CROSS;
      valid    <= 1'b1;
      req_seen <= sync_out;
      ack      <= ~ack;
    end else if (valid && bus.DEQ) begin
      valid    <= 1'b0;
    end
  end

  // Capture always takes the live sync_out, so a glitching source
  // flags PROTO_ERR but never wedges the FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      lvl   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            lvl <= sync_out;
            if (!NO_SETTLE) begin
              state <= SETTLE;
              cnt   <= LOAD;
            end else if (!space) begin
              state <= HOLD;
            end
          end
        end
        SETTLE: begin
          if (sync_out != lvl) perr <= 1'b1;
          if (cnt == '0) begin
            state <= space ? IDLE : HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (sync_out != lvl) perr <= 1'b1;
          if (space) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK_TOG   = ack;
  assign bus.D_OUT     = dout;
  assign bus.VALID     = valid;
  assign bus.PROTO_ERR = perr;

endmodule

// File: tb/tb_crossing_toggle_rx.sv
// Self-checking bench for crossing_toggle_rx across settle=0/3/4.
module tb_crossing_toggle_rx;

  localparam int W  = 8;
  localparam int SS = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  crossing_toggle_rx_if #(.width(W)) b0 ();
  crossing_toggle_rx_if #(.width(W)) b3 ();
  crossing_toggle_rx_if #(.width(W)) b4 ();

  crossing_toggle_rx #(
    .width(W), .init(8'h5A), .sync_stages(SS), .settle(0)
  ) dut0 (.CLK(CLK), .RST(RST), .bus(b0));

  crossing_toggle_rx #(
    .width(W), .init(8'h00), .sync_stages(SS), .settle(3)
  ) dut3 (.CLK(CLK), .RST(RST), .bus(b3));

  crossing_toggle_rx #(
    .width(W), .init(8'h00), .sync_stages(SS), .settle(4)
  ) dut4 (.CLK(CLK), .RST(RST), .bus(b4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet_sources();
    b0.D_CROSS = '0; b0.REQ_TOG = 1'b0; b0.DEQ = 1'b0;
    b3.D_CROSS = '0; b3.REQ_TOG = 1'b0; b3.DEQ = 1'b0;
    b4.D_CROSS = '0; b4.REQ_TOG = 1'b0; b4.DEQ = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (b0.VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", b0.VALID);
    end
    checks++;
    if (b0.D_OUT !== 8'h5A) begin
      errors++; $display("FAIL reset_dout: got %h want 5a", b0.D_OUT);
    end
    checks++;
    if (b0.ACK_TOG !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b want 0", b0.ACK_TOG);
    end
    checks++;
    if (b4.PROTO_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_perr: got %b want 0", b4.PROTO_ERR);
    end
    #3 RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    lat = SS + 0 + 1;
    b0.D_CROSS = 8'hA5;
    b0.REQ_TOG = ~b0.REQ_TOG;
    for (int n = 1; n <= lat; n++) begin
      tick();
      checks++;
      if (b0.VALID !== (n >= lat)) begin
        errors++;
        $display("FAIL basic_valid@%0d: got %b want %b", n, b0.VALID, n >= lat);
      end
    end
    checks++;
    if (b0.D_OUT !== 8'hA5) begin
      errors++; $display("FAIL basic_dout: got %h want a5", b0.D_OUT);
    end
    checks++;
    if (b0.ACK_TOG !== 1'b1) begin
      errors++; $display("FAIL basic_ack: got %b want 1", b0.ACK_TOG);
    end
    b0.DEQ = 1'b1;
    tick();
    b0.DEQ = 1'b0;
    checks++;
    if (b0.VALID !== 1'b0 || b0.D_OUT !== 8'hA5) begin
      errors++;
      $display("FAIL basic_deq: got v=%b d=%h want v=0 d=a5", b0.VALID, b0.D_OUT);
    end
  endtask

  task automatic test_settle();
    int lat;
    lat = SS + 3 + 1;
    b3.D_CROSS = 8'hA5;
    b3.REQ_TOG = ~b3.REQ_TOG;
    for (int n = 1; n <= lat; n++) begin
      tick();
      checks++;
      if (b3.VALID !== (n >= lat)) begin
        errors++;
        $display("FAIL settle_valid@%0d: got %b want %b", n, b3.VALID, n >= lat);
      end
    end
    checks++;
    if (b3.D_OUT !== 8'hA5 || b3.ACK_TOG !== 1'b1) begin
      errors++;
      $display("FAIL settle_cap: got d=%h a=%b want d=a5 a=1", b3.D_OUT, b3.ACK_TOG);
    end
    b3.D_CROSS = 8'h00;
    repeat (3) tick();
    checks++;
    if (b3.D_OUT !== 8'hA5 || b3.VALID !== 1'b1) begin
      errors++;
      $display("FAIL settle_hold: got d=%h v=%b want d=a5 v=1", b3.D_OUT, b3.VALID);
    end
    b3.DEQ = 1'b1;
    tick();
    b3.DEQ = 1'b0;
  endtask

  task automatic test_back_to_back();
    b0.D_CROSS = 8'h11;
    b0.REQ_TOG = ~b0.REQ_TOG;
    repeat (SS + 1) tick();
    checks++;
    if (b0.VALID !== 1'b1 || b0.D_OUT !== 8'h11 || b0.ACK_TOG !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got v=%b d=%h a=%b want v=1 d=11 a=0",
               b0.VALID, b0.D_OUT, b0.ACK_TOG);
    end
    b0.D_CROSS = 8'h3C;
    b0.REQ_TOG = ~b0.REQ_TOG;
    repeat (SS + 4) tick();
    checks++;
    if (b0.VALID !== 1'b1 || b0.D_OUT !== 8'h11 || b0.ACK_TOG !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b d=%h a=%b want v=1 d=11 a=0",
               b0.VALID, b0.D_OUT, b0.ACK_TOG);
    end
    b0.DEQ = 1'b1;
    tick();
    b0.DEQ = 1'b0;
    checks++;
    if (b0.VALID !== 1'b1 || b0.D_OUT !== 8'h3C || b0.ACK_TOG !== 1'b1) begin
      errors++;
      $display("FAIL b2b_swap: got v=%b d=%h a=%b want v=1 d=3c a=1",
               b0.VALID, b0.D_OUT, b0.ACK_TOG);
    end
    tick();
    checks++;
    if (b0.VALID !== 1'b1 || b0.D_OUT !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_keep: got v=%b d=%h want v=1 d=3c", b0.VALID, b0.D_OUT);
    end
    b0.DEQ = 1'b1;
    tick();
    b0.DEQ = 1'b0;
    checks++;
    if (b0.VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got %b want 0", b0.VALID);
    end
  endtask

  task automatic test_proto();
    b4.D_CROSS = 8'h99;
    b4.REQ_TOG = 1'b1;
    repeat (2) tick();
    checks++;
    if (b4.PROTO_ERR !== 1'b0) begin
      errors++; $display("FAIL proto_early: got %b want 0", b4.PROTO_ERR);
    end
    b4.REQ_TOG = 1'b0;
    repeat (8) tick();
    checks++;
    if (b4.PROTO_ERR !== 1'b1 || b4.VALID !== 1'b1) begin
      errors++;
      $display("FAIL proto_flag: got e=%b v=%b want e=1 v=1", b4.PROTO_ERR, b4.VALID);
    end
    b4.DEQ = 1'b1;
    tick();
    b4.DEQ = 1'b0;
    b4.D_CROSS = 8'hC3;
    b4.REQ_TOG = 1'b1;
    repeat (SS + 4 + 1) tick();
    checks++;
    if (b4.VALID !== 1'b1 || b4.D_OUT !== 8'hC3 || b4.PROTO_ERR !== 1'b1) begin
      errors++;
      $display("FAIL proto_recover: got v=%b d=%h e=%b want v=1 d=c3 e=1",
               b4.VALID, b4.D_OUT, b4.PROTO_ERR);
    end
  endtask

  task automatic test_reset_mid();
    b0.D_CROSS = 8'h77;
    b0.REQ_TOG = ~b0.REQ_TOG;
    repeat (SS + 1) tick();
    checks++;
    if (b0.VALID !== 1'b1 || b0.D_OUT !== 8'h77) begin
      errors++;
      $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=77", b0.VALID, b0.D_OUT);
    end
    #3 RST = 1'b1;
    #1;
    checks++;
    if (b0.VALID !== 1'b0 || b0.D_OUT !== 8'h5A || b0.ACK_TOG !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got v=%b d=%h a=%b want v=0 d=5a a=0",
               b0.VALID, b0.D_OUT, b0.ACK_TOG);
    end
    checks++;
    if (b4.PROTO_ERR !== 1'b0 || b4.VALID !== 1'b0) begin
      errors++;
      $display("FAIL rmid_perr: got e=%b v=%b want e=0 v=0", b4.PROTO_ERR, b4.VALID);
    end
    quiet_sources();
    tick();
    checks++;
    if (b0.VALID !== 1'b0 || b0.D_OUT !== 8'h5A) begin
      errors++;
      $display("FAIL rmid_held: got v=%b d=%h want v=0 d=5a", b0.VALID, b0.D_OUT);
    end
    #2 RST = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [W-1:0] q[$];
    logic [W-1:0] w;
    logic [W-1:0] exp;
    logic         deq;
    int           sent;
    int           got;
    int           cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 50 && cyc < 4000) begin
      deq = 1'($urandom_range(0, 1));
      if (b0.VALID && deq) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %h want none", b0.D_OUT);
        end else begin
          exp = q.pop_front();
          if (b0.D_OUT !== exp) begin
            errors++;
            $display("FAIL stream_word%0d: got %h want %h", got, b0.D_OUT, exp);
          end
        end
        got++;
      end
      b0.DEQ = deq;
      if (sent < 50 && b0.ACK_TOG == b0.REQ_TOG) begin
        w = W'($urandom);
        b0.D_CROSS = w;
        b0.REQ_TOG = ~b0.REQ_TOG;
        q.push_back(w);
        sent++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (got != 50 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d left %0d want 50 left 0", got, q.size());
    end
    b0.DEQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (b0.VALID !== 1'b0) begin
        errors++; $display("FAIL stream_dup@%0d: got %b want 0", i, b0.VALID);
      end
    end
    b0.DEQ = 1'b0;
  endtask

  initial begin
    quiet_sources();
    test_reset();
    test_basic();
    test_settle();
    test_back_to_back();
    test_proto();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
